// File: rtl/seg_display_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package seg_display_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned DATA_W  = 16;

  // Word driven when no source has been granted yet.
  localparam logic [DATA_W-1:0] BLANK_CODE = '0;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSelect = 2'd1,
    StShow   = 2'd2
  } state_e;

  function automatic logic [NUM_SRC-1:0] onehot4(input logic [1:0] idx);
    return NUM_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker; the last grant has lowest priority.
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic [1:0] pick_o,
  output logic       any_o
);

  // Walk from the farthest candidate to the nearest so the nearest request wins.
  always_comb begin
    pick_o = last_i;
    for (int i = 4; i >= 1; i--) begin
      if (req_i[last_i + 2'(i)]) pick_o = last_i + 2'(i);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/seg_display_scheduler.sv
// Round-robin time-sharing of the 4-digit display among four requesters,
// holding each grant for a programmable dwell period.
module seg_display_scheduler
  import seg_display_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [NUM_SRC-1:0]          i_Req,
  input  logic [NUM_SRC*DATA_W-1:0]   i_Data,
  input  logic                        i_Lock,
  output logic [NUM_SRC-1:0]          o_Ack,
  output logic [DATA_W-1:0]           o_Data,
  output logic [1:0]                  o_Active_Source,
  output logic                        o_Blank
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DWELL_CYCLES - 1);

  state_e            state_q;
  logic [1:0]        last_src_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [1:0]        pick;
  logic              any_req;
  logic [DATA_W-1:0] pick_word;
  logic [DATA_W-1:0] active_word;
  logic              other_req;
  logic              dwell_done;

  rr_pick4 u_pick (
    .req_i  (i_Req),
    .last_i (last_src_q),
    .pick_o (pick),
    .any_o  (any_req)
  );

  assign pick_word   = i_Data[{pick, 4'b0000} +: DATA_W];
  assign active_word = i_Data[{o_Active_Source, 4'b0000} +: DATA_W];
  assign other_req   = |(i_Req & ~onehot4(o_Active_Source));
  assign dwell_done  = (cnt_q == CntMax);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q         <= StIdle;
      last_src_q      <= 2'd3;
      cnt_q           <= '0;
      o_Ack           <= '0;
      o_Data          <= BLANK_CODE;
      o_Active_Source <= 2'd0;
      o_Blank         <= 1'b1;
    end else begin
      o_Ack <= '0;
      unique case (state_q)
        StIdle: begin
          o_Blank <= 1'b1;
          if (|i_Req) state_q <= StSelect;
        end
        StSelect: begin
          if (any_req) begin
            state_q         <= StShow;
            o_Active_Source <= pick;
            last_src_q      <= pick;
            o_Ack           <= onehot4(pick);
            cnt_q           <= '0;
            o_Blank         <= 1'b0;
            o_Data          <= pick_word;
          end else begin
            state_q <= StIdle;
            o_Blank <= 1'b1;
          end
        end
        StShow: begin
          o_Blank <= 1'b0;
          o_Data  <= active_word;
          cnt_q   <= dwell_done ? cnt_q : cnt_q + 1'b1;
          // A dropped request releases the display even while locked.
          if (!i_Req[o_Active_Source]) begin
            state_q <= StSelect;
          end else if (i_Lock) begin
            state_q <= StShow;
          end else if (dwell_done) begin
            if (other_req) state_q <= StSelect;
            else           cnt_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler with a grant scoreboard (DWELL_CYCLES=8).
module tb_seg_display_scheduler;

  typedef struct {
    logic [1:0]  src;
    logic [15:0] data;
  } grant_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [63:0] din = 64'h0;
  logic        lock = 1'b0;
  logic [3:0]  ack;
  logic [15:0] dout;
  logic [1:0]  act_src;
  logic        blank;

  grant_t exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  seg_display_scheduler #(
    .DWELL_CYCLES (8),
    .CNT_W        (4)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_Req           (req),
    .i_Data          (din),
    .i_Lock          (lock),
    .o_Ack           (ack),
    .o_Data          (dout),
    .o_Active_Source (act_src),
    .o_Blank         (blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] src, input logic [15:0] data);
    grant_t g;
    g.src  = src;
    g.data = data;
    exp_q.push_back(g);
  endtask

  // Scoreboard monitor: every grant pulse is matched against the next expected grant.
  always @(negedge clk) begin
    if (!rst && ack != 4'b0000) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", {28'h0, ack}, 32'h0);
      end else begin
        grant_t g;
        logic [3:0] oh;
        g  = exp_q.pop_front();
        oh = 4'b0001 << g.src;
        chk("sb_ack", {28'h0, ack}, {28'h0, oh});
        chk("sb_src", {30'h0, act_src}, {30'h0, g.src});
        chk("sb_data", {16'h0, dout}, {16'h0, g.data});
      end
    end
  end

  logic [15:0] words [4];

  initial begin
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;

    // Reset state and idle blanking
    repeat (3) edge_step();
    chk("rst_blank", {31'h0, blank}, 32'h1);
    chk("rst_data", {16'h0, dout}, 32'h0);
    chk("rst_ack", {28'h0, ack}, 32'h0);
    chk("rst_src", {30'h0, act_src}, 32'h0);
    rst = 1'b0;
    repeat (5) begin
      edge_step();
      chk("idle_blank", {31'h0, blank}, 32'h1);
      chk("idle_data", {16'h0, dout}, 32'h0);
    end

    // Single requester, two-edge latency, held with no re-ack
    din[15:0] = 16'h1234;
    push(2'd0, 16'h1234);
    req = 4'b0001;
    edge_step();
    chk("t2_select_ack", {28'h0, ack}, 32'h0);
    chk("t2_select_blank", {31'h0, blank}, 32'h1);
    edge_step();
    chk("t2_grant_ack", {28'h0, ack}, 32'h1);
    chk("t2_grant_data", {16'h0, dout}, 32'h1234);
    chk("t2_grant_blank", {31'h0, blank}, 32'h0);
    repeat (20) begin
      edge_step();
      chk("t2_hold_ack", {28'h0, ack}, 32'h0);
      chk("t2_hold_data", {16'h0, dout}, 32'h1234);
    end
    req = 4'b0000;
    edge_step();
    chk("t2_drop_blank1", {31'h0, blank}, 32'h0);
    edge_step();
    chk("t2_drop_blank2", {31'h0, blank}, 32'h1);
    chk("t2_drop_data", {16'h0, dout}, 32'h1234);

    // Full rotation 0,1,2,3,0 after a fresh reset
    rst = 1'b1;
    edge_step();
    rst = 1'b0;
    din = 64'h4444_3333_2222_1111;
    for (int g = 0; g < 5; g++) push(2'(g % 4), words[g % 4]);
    req = 4'b1111;
    edge_step();
    edge_step();
    for (int g = 0; g < 5; g++) begin
      chk("rot_ack", {28'h0, ack}, {28'h0, 4'b0001 << (g % 4)});
      chk("rot_src", {30'h0, act_src}, g % 4);
      for (int k = 1; k < 8; k++) begin
        edge_step();
        chk("rot_show_data", {16'h0, dout}, {16'h0, words[g % 4]});
        chk("rot_show_ack", {28'h0, ack}, 32'h0);
      end
      if (g < 4) begin
        edge_step();
        chk("rot_select_data", {16'h0, dout}, {16'h0, words[g % 4]});
        chk("rot_select_blank", {31'h0, blank}, 32'h0);
        chk("rot_select_ack", {28'h0, ack}, 32'h0);
        edge_step();
      end
    end
    req = 4'b0000;
    edge_step();
    edge_step();
    chk("rot_idle_blank", {31'h0, blank}, 32'h1);

    // Lock holds source 1; dropping its request releases even under lock
    push(2'd1, 16'h2222);
    req = 4'b0110;
    edge_step();
    edge_step();
    chk("lock_grant_ack", {28'h0, ack}, 32'h2);
    lock = 1'b1;
    repeat (60) begin
      edge_step();
      chk("lock_hold_src", {30'h0, act_src}, 32'h1);
    end
    push(2'd2, 16'h3333);
    req = 4'b0100;
    edge_step();
    chk("lock_release_ack0", {28'h0, ack}, 32'h0);
    edge_step();
    chk("lock_release_ack", {28'h0, ack}, 32'h4);
    chk("lock_release_src", {30'h0, act_src}, 32'h2);

    // Live data tracking with one-cycle latency, then drop-all to idle
    din = 64'h4444_BEEF_2222_1111;
    chk("track_before", {16'h0, dout}, 32'h3333);
    edge_step();
    chk("track_after", {16'h0, dout}, 32'hBEEF);
    req = 4'b0000;
    edge_step();
    chk("dropall_blank1", {31'h0, blank}, 32'h0);
    edge_step();
    chk("dropall_blank2", {31'h0, blank}, 32'h1);
    chk("dropall_data", {16'h0, dout}, 32'hBEEF);
    lock = 1'b0;

    // Asynchronous reset mid-show on source 3, then pointer restart
    push(2'd3, 16'h4444);
    req = 4'b1000;
    edge_step();
    edge_step();
    chk("s3_grant_src", {30'h0, act_src}, 32'h3);
    repeat (3) edge_step();
    rst = 1'b1;
    #1;
    chk("async_rst_blank", {31'h0, blank}, 32'h1);
    chk("async_rst_data", {16'h0, dout}, 32'h0);
    chk("async_rst_src", {30'h0, act_src}, 32'h0);
    chk("async_rst_ack", {28'h0, ack}, 32'h0);
    edge_step();
    edge_step();
    push(2'd3, 16'h4444);
    rst = 1'b0;
    edge_step();
    chk("restart_select_ack", {28'h0, ack}, 32'h0);
    edge_step();
    chk("restart_grant_ack", {28'h0, ack}, 32'h8);
    chk("restart_grant_src", {30'h0, act_src}, 32'h3);
    chk("restart_grant_data", {16'h0, dout}, 32'h4444);

    edge_step();
    chk("queue_empty", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
